// File: rtl/bsg_chip_pkg.sv
// Shared types and defaults for the chip reset sequencer.
// The state codes double as the externally visible stage_o encoding.
package bsg_chip_pkg;

    localparam int unsigned bsg_chip_default_hold_cycles_lp    = 64;
    localparam int unsigned bsg_chip_default_timeout_cycles_lp = 4096;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        HOLD_ALL   = 4'd1,
        REL_IO     = 4'd2,
        REL_CORE   = 4'd3,
        WAIT_LINK  = 4'd4,
        REL_ROUTER = 4'd5,
        REL_BP     = 4'd6,
        DONE       = 4'd7,
        ERROR      = 4'd8
    } bsg_chip_reset_state_e;

    // Counter must hold the larger of the two load values without wrapping.
    function automatic int unsigned bsg_chip_reset_ctr_width(input int unsigned hold_cycles,
                                                             input int unsigned timeout_cycles);
        int unsigned max_cycles;
        max_cycles = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/bsg_counter_set_down.sv
// Loadable down-counter that saturates at zero.
// A load takes priority over counting in the same cycle.
module bsg_counter_set_down #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               set_i,
    input  logic [width_p-1:0] val_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_r;

    // Load on set, otherwise decrement until zero and hold there.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (set_i) begin
            count_r <= val_i;
        end else if (down_i && (count_r != '0)) begin
            count_r <= count_r - width_p'(1);
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/bsg_chip_reset_sequencer.sv
// Chip reset sequencer: releases the link IO, link core / CT, router and
// BP domain resets in order, waiting for link training between the core
// and router stages. All outputs are registered Moore decodes of the state.
// Optional feature: define BSG_CHIP_RESET_SEQ_TIMEOUT_EN to bound the
// link wait with timeout_cycles_p and enter ERROR on expiry.
module bsg_chip_reset_sequencer
    import bsg_chip_pkg::*;
#(
    parameter int unsigned hold_cycles_p    = bsg_chip_default_hold_cycles_lp,
    parameter int unsigned timeout_cycles_p = bsg_chip_default_timeout_cycles_lp
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic       link_ready_i,
    output logic       link_io_reset_o,
    output logic       link_core_reset_o,
    output logic       ct_reset_o,
    output logic       router_reset_o,
    output logic       bp_reset_o,
    output logic [3:0] stage_o,
    output logic       done_o,
    output logic       error_o
);

    localparam int unsigned ctr_width_lp = bsg_chip_reset_ctr_width(hold_cycles_p, timeout_cycles_p);
    localparam logic [ctr_width_lp-1:0] hold_load_lp = ctr_width_lp'(hold_cycles_p - 1);
`ifdef BSG_CHIP_RESET_SEQ_TIMEOUT_EN
    localparam logic [ctr_width_lp-1:0] timeout_load_lp = ctr_width_lp'(timeout_cycles_p - 1);
`endif

    bsg_chip_reset_state_e      state_r;
    bsg_chip_reset_state_e      state_n;
    logic                       ctr_set;
    logic [ctr_width_lp-1:0]    ctr_val;
    logic [ctr_width_lp-1:0]    ctr_count;
    logic                       ctr_zero;

    assign ctr_zero = (ctr_count == '0);

    // One counter times every stage; it is reloaded on entry to each timed stage.
    bsg_counter_set_down #(
        .width_p (ctr_width_lp)
    ) stage_ctr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .set_i     (ctr_set),
        .val_i     (ctr_val),
        .down_i    (1'b1),
        .count_o   (ctr_count)
    );

    // Next-state and counter-load decision for the sequence.
    always_comb begin
        state_n = state_r;
        ctr_set = 1'b0;
        ctr_val = hold_load_lp;
        unique case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_n = HOLD_ALL;
                    ctr_set = 1'b1;
                end
            end
            HOLD_ALL: begin
                if (ctr_zero) begin
                    state_n = REL_IO;
                    ctr_set = 1'b1;
                end
            end
            REL_IO: begin
                if (ctr_zero) begin
                    state_n = REL_CORE;
                    ctr_set = 1'b1;
                end
            end
            REL_CORE: begin
                if (ctr_zero) begin
                    state_n = WAIT_LINK;
`ifdef BSG_CHIP_RESET_SEQ_TIMEOUT_EN
                    ctr_set = 1'b1;
                    ctr_val = timeout_load_lp;
`endif
                end
            end
            WAIT_LINK: begin
                // Link ready takes priority over an expiring timeout.
                if (link_ready_i) begin
                    state_n = REL_ROUTER;
                    ctr_set = 1'b1;
                end
`ifdef BSG_CHIP_RESET_SEQ_TIMEOUT_EN
                else if (ctr_zero) begin
                    state_n = ERROR;
                end
`endif
            end
            REL_ROUTER: begin
                if (ctr_zero) begin
                    state_n = REL_BP;
                    ctr_set = 1'b1;
                end
            end
            REL_BP: begin
                if (ctr_zero) begin
                    state_n = DONE;
                end
            end
            DONE, ERROR: begin
                if (start_i) begin
                    state_n = HOLD_ALL;
                    ctr_set = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register plus registered Moore decode of the current state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r           <= IDLE;
            link_io_reset_o   <= 1'b1;
            link_core_reset_o <= 1'b1;
            ct_reset_o        <= 1'b1;
            router_reset_o    <= 1'b1;
            bp_reset_o        <= 1'b1;
            stage_o           <= 4'd0;
            done_o            <= 1'b0;
        end else begin
            state_r           <= state_n;
            link_io_reset_o   <= !(state_r inside {REL_IO, REL_CORE, WAIT_LINK, REL_ROUTER, REL_BP, DONE});
            link_core_reset_o <= !(state_r inside {REL_CORE, WAIT_LINK, REL_ROUTER, REL_BP, DONE});
            ct_reset_o        <= !(state_r inside {REL_CORE, WAIT_LINK, REL_ROUTER, REL_BP, DONE});
            router_reset_o    <= !(state_r inside {REL_ROUTER, REL_BP, DONE});
            bp_reset_o        <= !(state_r inside {REL_BP, DONE});
            stage_o           <= state_r;
            done_o            <= (state_r == DONE);
        end
    end

`ifdef BSG_CHIP_RESET_SEQ_TIMEOUT_EN
    // Registered error flag, high only while in ERROR.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            error_o <= 1'b0;
        end else begin
            error_o <= (state_r == ERROR);
        end
    end
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: doc/bsg_chip_reset_sequencer.md
BSG_CHIP_RESET_SEQUENCER -- requirements
Module: bsg_chip_reset_sequencer

Interface
REQ-001 SHALL take parameter hold_cycles_p, default 64: cycles spent in each timed stage; legal values are >=1.
REQ-002 SHALL take parameter timeout_cycles_p, default 4096: maximum WAIT_LINK cycles (used only when the timeout feature is compiled in).
REQ-003 SHALL have clk_i  input  1  single sequencer clock.
REQ-004 SHALL have reset_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have start_i  input  1  start/restart request, sampled each cycle.
REQ-006 SHALL have link_ready_i  input  1  link training complete, from the IO complex.
REQ-007 SHALL have link_io_reset_o, link_core_reset_o, ct_reset_o, router_reset_o, bp_reset_o  output  1 each  active-high domain resets.
REQ-008 SHALL have stage_o  output  4  current state encoding.
REQ-009 SHALL have done_o  output  1  sequence complete.
REQ-010 SHALL have error_o  output  1  link timeout.

Function
REQ-011 States and stage_o codes SHALL be: IDLE=0, HOLD_ALL=1, REL_IO=2, REL_CORE=3, WAIT_LINK=4, REL_ROUTER=5, REL_BP=6, DONE=7, ERROR=8.
REQ-012 All outputs SHALL be registered, Moore-decoded from state; no input-to-output combinational path.
REQ-013 Reset outputs SHALL be asserted in IDLE, HOLD_ALL and ERROR.
REQ-014 Domain resets SHALL be deasserted cumulatively: link_io from REL_IO; link_core and ct from REL_CORE; router from REL_ROUTER; bp from REL_BP. Once deasserted, each stays deasserted through DONE.
REQ-015 IDLE SHALL go to HOLD_ALL on start_i=1.
REQ-016 Each timed stage (HOLD_ALL, REL_IO, REL_CORE, REL_ROUTER, REL_BP) SHALL last exactly hold_cycles_p cycles: the down-counter loads hold_cycles_p-1 on entry and the state advances when the count reaches 0.
REQ-017 WAIT_LINK SHALL go to REL_ROUTER in the first cycle link_ready_i=1; it lasts at least 1 cycle.
REQ-018 start_i SHALL be ignored in HOLD_ALL through REL_BP.
REQ-019 start_i in DONE or ERROR SHALL go to HOLD_ALL, reasserting all resets and clearing done_o/error_o next cycle.
REQ-020 done_o SHALL be 1 only in DONE; error_o only in ERROR.
REQ-021 link_ready_i falling while in DONE SHALL have no effect.
REQ-022 Counter width SHALL be $clog2(max(hold_cycles_p,timeout_cycles_p)+1); no wrap-around.

Reset
REQ-023 reset_n_i=0 SHALL asynchronously force state IDLE, counter 0, all domain resets 1, done_o=0, error_o=0, stage_o=0, including mid-sequence.
REQ-024 After reset_n_i deasserts, the block SHALL stay in IDLE until start_i.

Configuration
REQ-025 With BSG_CHIP_RESET_SEQ_TIMEOUT_EN defined, WAIT_LINK SHALL load timeout_cycles_p-1 on entry and go to ERROR when the count is 0 and link_ready_i=0; if link_ready_i=1 in that same cycle, the ready transition wins.
REQ-026 Without the macro, WAIT_LINK SHALL wait indefinitely, ERROR SHALL be unreachable, and error_o SHALL be tied 0.

Structure
REQ-027 The state enum typedef and the default hold/timeout constants SHALL live in bsg_chip_pkg.
REQ-028 Stage timing SHALL use one bsg_counter_set_down sub-module instance, shared by timed stages and the timeout.

Verification (hold_cycles_p=4, timeout_cycles_p=16)
REQ-029 Reset, start_i pulse at cycle 0, link_ready_i held 1 -> link_io_reset_o falls at cycle 5; link_core/ct at 9; router at 14; bp at 18; done_o=1 from cycle 22.
REQ-030 link_ready_i rises 10 cycles after WAIT_LINK entry -> stage_o=4 for exactly 10 cycles, then REL_ROUTER; error_o stays 0.
REQ-031 Macro on, link_ready_i held 0 -> ERROR after 16 WAIT_LINK cycles, error_o=1, all resets 1; start_i then yields HOLD_ALL.
REQ-032 Macro on, link_ready_i rises exactly on the 16th WAIT_LINK cycle -> REL_ROUTER, error_o never 1.
REQ-033 reset_n_i pulsed low during REL_ROUTER (asynchronously, mid-cycle) -> all resets 1 immediately, stage_o=0; start_i repeated during HOLD_ALL is ignored.
REQ-034 start_i in DONE -> all resets reasserted and done_o=0 next cycle; the full sequence then replays with the same timing as REQ-029.
